// File: rtl/btn_debounce_multi.sv
// N-channel push-button debouncer: 2-flop synchroniser, shared sample-tick prescaler,
// per-channel stability FSM producing clean levels and press/release/long pulses.

module btn_debounce_chan #(
  parameter int STABLE_TICKS = 3,
  parameter int LONG_TICKS   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic samp,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_pulse
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam bit FAST = (STABLE_TICKS == 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [HW-1:0]   hold_reg;
  logic            level_reg;
  logic            press_reg;
  logic            rel_reg;
  logic            long_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RELEASED;
      cnt_reg   <= '0;
      hold_reg  <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      rel_reg   <= 1'b0;
      long_reg  <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      rel_reg   <= 1'b0;
      long_reg  <= 1'b0;
      if (tick) begin
        case (state_reg)
          RELEASED: begin
            if (samp) begin
              if (FAST) begin
                state_reg <= PRESSED;
                cnt_reg   <= '0;
                hold_reg  <= '0;
                level_reg <= 1'b1;
                press_reg <= 1'b1;
              end else begin
                state_reg <= PRESS_PEND;
                cnt_reg   <= CNT_ONE;
              end
            end
          end
          PRESS_PEND: begin
            if (!samp) begin
              state_reg <= RELEASED;
              cnt_reg   <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_reg <= PRESSED;
              cnt_reg   <= '0;
              hold_reg  <= '0;
              level_reg <= 1'b1;
              press_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          PRESSED, RELEASE_PEND: begin
            // Hold time keeps running through a tentative release; saturation
            // guarantees a single long pulse per press.
            if (hold_reg != HOLD_MAX) begin
              hold_reg <= hold_reg + HOLD_ONE;
              if (hold_reg == HOLD_LAST) long_reg <= 1'b1;
            end
            if (state_reg == PRESSED) begin
              if (!samp) begin
                if (FAST) begin
                  state_reg <= RELEASED;
                  cnt_reg   <= '0;
                  hold_reg  <= '0;
                  level_reg <= 1'b0;
                  rel_reg   <= 1'b1;
                end else begin
                  state_reg <= RELEASE_PEND;
                  cnt_reg   <= CNT_ONE;
                end
              end
            end else begin
              if (samp) begin
                state_reg <= PRESSED;
                cnt_reg   <= '0;
              end else if (cnt_reg == CNT_LAST) begin
                state_reg <= RELEASED;
                cnt_reg   <= '0;
                hold_reg  <= '0;
                level_reg <= 1'b0;
                rel_reg   <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end
          end
          default: begin
            state_reg <= RELEASED;
            cnt_reg   <= '0;
          end
        endcase
      end
    end
  end

  assign level      = level_reg;
  assign press      = press_reg;
  assign rel        = rel_reg;
  assign long_pulse = long_reg;
endmodule

module btn_debounce_multi #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 250000,
  parameter int STABLE_TICKS = 3,
  parameter int LONG_TICKS   = 200,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long,
  output logic            tick
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(TICK_DIV - 2);
  localparam logic IDLE_RAW = (ACTIVE_LOW != 0);

  logic [PW-1:0]   presc_reg;
  logic            tick_reg;
  logic [N_CH-1:0] sync1_reg;
  logic [N_CH-1:0] sync2_reg;
  logic [N_CH-1:0] samp;

  // tick_reg is high exactly while presc_reg sits at TICK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      if (presc_reg == PRESC_LAST) presc_reg <= '0;
      else                         presc_reg <= presc_reg + PRESC_ONE;
      tick_reg <= (presc_reg == PRESC_PRE);
    end
  end

  // Synchronisers reset to the idle raw level so no phantom press follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= {N_CH{IDLE_RAW}};
      sync2_reg <= {N_CH{IDLE_RAW}};
    end else begin
      sync1_reg <= btn_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign samp = sync2_reg ^ {N_CH{IDLE_RAW}};
  assign tick = tick_reg;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      btn_debounce_chan #(
        .STABLE_TICKS (STABLE_TICKS),
        .LONG_TICKS   (LONG_TICKS)
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick_reg),
        .samp       (samp[gi]),
        .level      (btn_level[gi]),
        .press      (btn_press[gi]),
        .rel        (btn_release[gi]),
        .long_pulse (btn_long[gi])
      );
    end
  endgenerate
endmodule
